// File: rtl/register_file.sv
// Architectural register file with rename/status table for the RV32I out-of-order core.
// Issue marks destinations pending on a ROB tag; ROB commits write values and release matching tags.
module register_file #(
    parameter int ROB_WIDTH = 4,
    parameter int REG_COUNT = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear_signal,
    input  logic                 issue_signal,
    input  logic [4:0]           issue_rd_id,
    input  logic [ROB_WIDTH-1:0] issue_tag,
    input  logic [4:0]           rs1_id,
    input  logic [4:0]           rs2_id,
    output logic [31:0]          rs1_value,
    output logic [31:0]          rs2_value,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic [ROB_WIDTH-1:0] rs1_tag,
    output logic [ROB_WIDTH-1:0] rs2_tag,
    input  logic                 reg_done,
    input  logic [31:0]          reg_value,
    input  logic [4:0]           reg_id,
    input  logic [ROB_WIDTH-1:0] reg_tag
);

    localparam int ID_W  = 5;
    localparam int RD_W  = 1 + ROB_WIDTH + 32;

    logic [31:0]          r_value [REG_COUNT];
    logic [ROB_WIDTH-1:0] r_tag   [REG_COUNT];
    logic [REG_COUNT-1:0] r_busy;

    logic [REG_COUNT-1:0] w_commit_hit;
    logic [REG_COUNT-1:0] w_issue_hit;
    logic [REG_COUNT-1:0] w_release;
    logic [RD_W-1:0]      w_rd1;
    logic [RD_W-1:0]      w_rd2;

    // Read one source: x0 is hardwired zero, a same-cycle matching commit is forwarded.
    function automatic logic [RD_W-1:0] read_port(
        input logic [ID_W-1:0]      id,
        input logic [31:0]          val,
        input logic [ROB_WIDTH-1:0] tag,
        input logic                 busy,
        input logic                 c_done,
        input logic [ID_W-1:0]      c_id,
        input logic [ROB_WIDTH-1:0] c_tag,
        input logic [31:0]          c_val
    );
        logic [RD_W-1:0] res;
        if (id == 5'd0) begin
            res = {1'b0, {ROB_WIDTH{1'b0}}, 32'd0};
        end else if (c_done && (c_id == id) && busy && (tag == c_tag)) begin
            res = {1'b0, tag, c_val};
        end else begin
            res = {busy, tag, val};
        end
        return res;
    endfunction

    // Per-register decode of commit, issue and tag-matched busy release.
    always_comb begin
        w_commit_hit = {REG_COUNT{1'b0}};
        w_issue_hit  = {REG_COUNT{1'b0}};
        w_release    = {REG_COUNT{1'b0}};
        for (int i = 1; i < REG_COUNT; i++) begin
            w_commit_hit[i] = reg_done && (reg_id == ID_W'(i));
            w_issue_hit[i]  = issue_signal && !clear_signal && (issue_rd_id == ID_W'(i));
            w_release[i]    = w_commit_hit[i] && r_busy[i] && (r_tag[i] == reg_tag);
        end
    end

    // State update: value writes are independent; busy priority is flush > issue > release.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_busy <= {REG_COUNT{1'b0}};
            for (int i = 0; i < REG_COUNT; i++) begin
                r_value[i] <= 32'd0;
                r_tag[i]   <= {ROB_WIDTH{1'b0}};
            end
        end else if (rdy_in) begin
            for (int i = 1; i < REG_COUNT; i++) begin
                if (w_commit_hit[i]) begin
                    r_value[i] <= reg_value;
                end
                if (clear_signal) begin
                    r_busy[i] <= 1'b0;
                end else if (w_issue_hit[i]) begin
                    r_busy[i] <= 1'b1;
                    r_tag[i]  <= issue_tag;
                end else if (w_release[i]) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    // Zero-latency source reads from pre-issue state.
    always_comb begin
        w_rd1 = read_port(rs1_id, r_value[rs1_id], r_tag[rs1_id], r_busy[rs1_id],
                          reg_done, reg_id, reg_tag, reg_value);
        w_rd2 = read_port(rs2_id, r_value[rs2_id], r_tag[rs2_id], r_busy[rs2_id],
                          reg_done, reg_id, reg_tag, reg_value);
    end

    assign rs1_busy  = w_rd1[RD_W-1];
    assign rs1_tag   = w_rd1[32 +: ROB_WIDTH];
    assign rs1_value = w_rd1[31:0];
    assign rs2_busy  = w_rd2[RD_W-1];
    assign rs2_tag   = w_rd2[32 +: ROB_WIDTH];
    assign rs2_value = w_rd2[31:0];

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: driver pushes model predictions, monitor compares reads.
module tb_register_file;

    localparam int RW = 4;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          rdy_in = 1'b0;
    logic          clear_signal = 1'b0;
    logic          issue_signal = 1'b0;
    logic [4:0]    issue_rd_id = 5'd0;
    logic [RW-1:0] issue_tag = '0;
    logic [4:0]    rs1_id = 5'd0;
    logic [4:0]    rs2_id = 5'd0;
    logic [31:0]   rs1_value, rs2_value;
    logic          rs1_busy, rs2_busy;
    logic [RW-1:0] rs1_tag, rs2_tag;
    logic          reg_done = 1'b0;
    logic [31:0]   reg_value = 32'd0;
    logic [4:0]    reg_id = 5'd0;
    logic [RW-1:0] reg_tag = '0;

    register_file #(.ROB_WIDTH(RW), .REG_COUNT(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_signal(clear_signal),
        .issue_signal(issue_signal), .issue_rd_id(issue_rd_id), .issue_tag(issue_tag),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_value(rs1_value), .rs2_value(rs2_value),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
        .reg_done(reg_done), .reg_value(reg_value), .reg_id(reg_id), .reg_tag(reg_tag)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic          iss;
        logic [4:0]    rd;
        logic [RW-1:0] itag;
        logic [4:0]    s1;
        logic [4:0]    s2;
        logic          done;
        logic [4:0]    id;
        logic [31:0]   val;
        logic [RW-1:0] ctag;
        logic          clr;
        logic          rdy;
    } stim_t;

    typedef struct {
        string         nm;
        logic [31:0]   v1;
        logic [31:0]   v2;
        logic          b1;
        logic          b2;
        logic [RW-1:0] t1;
        logic [RW-1:0] t2;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   stim_done = 1'b0;

    // Reference model: committed value and pending producer tag (-1 = no producer in flight)
    logic [31:0] m_val [32];
    int          m_pend [32];

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i]  = 32'd0;
            m_pend[i] = -1;
        end
    endfunction

    function automatic void model_read(input stim_t s, input logic [4:0] src,
                                       output logic [31:0] v, output logic b, output logic [RW-1:0] t);
        t = '0;
        if (src == 5'd0) begin
            v = 32'd0; b = 1'b0;
        end else if (s.done && s.id == src && m_pend[src] >= 0 && m_pend[src] == int'(s.ctag)) begin
            v = s.val; b = 1'b0;
        end else begin
            v = m_val[src];
            b = (m_pend[src] >= 0);
            if (b) t = RW'(m_pend[src]);
        end
    endfunction

    function automatic void model_update(input stim_t s);
        if (!s.rdy) return;
        if (s.done && s.id != 5'd0) m_val[s.id] = s.val;
        if (s.clr) begin
            for (int i = 0; i < 32; i++) m_pend[i] = -1;
        end else begin
            if (s.done && s.id != 5'd0 && m_pend[s.id] == int'(s.ctag)) m_pend[s.id] = -1;
            if (s.iss && s.rd != 5'd0) m_pend[s.rd] = int'(s.itag);
        end
    endfunction

    function automatic stim_t idle(input logic [4:0] a, input logic [4:0] b);
        stim_t s;
        s.iss = 1'b0; s.rd = 5'd0; s.itag = '0; s.s1 = a; s.s2 = b;
        s.done = 1'b0; s.id = 5'd0; s.val = 32'd0; s.ctag = '0; s.clr = 1'b0; s.rdy = 1'b1;
        return s;
    endfunction

    task automatic step(input stim_t s, input string nm);
        exp_t e;
        @(negedge clk_in);
        #1;
        issue_signal = s.iss; issue_rd_id = s.rd; issue_tag = s.itag;
        rs1_id = s.s1; rs2_id = s.s2;
        reg_done = s.done; reg_id = s.id; reg_value = s.val; reg_tag = s.ctag;
        clear_signal = s.clr; rdy_in = s.rdy;
        e.nm = nm;
        model_read(s, s.s1, e.v1, e.b1, e.t1);
        model_read(s, s.s2, e.v2, e.b2, e.t2);
        sb_q.push_back(e);
        model_update(s);
    endtask

    // Asynchronous reset mid-cycle: outputs must clear before any clock edge
    task automatic async_reset(input logic [4:0] a, input logic [4:0] b, input string nm);
        exp_t e;
        @(negedge clk_in);
        #1;
        rst_in = 1'b0;
        issue_signal = 1'b0; reg_done = 1'b0; clear_signal = 1'b0;
        rs1_id = a; rs2_id = b;
        model_reset();
        e.nm = nm; e.v1 = 32'd0; e.v2 = 32'd0; e.b1 = 1'b0; e.b2 = 1'b0; e.t1 = '0; e.t2 = '0;
        sb_q.push_back(e);
        @(negedge clk_in);
        #1;
        rst_in = 1'b1;
    endtask

    // Monitor: read outputs are valid every cycle once inputs settle, before the next rising edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                total++;
                if (rs1_value !== e.v1 || rs1_busy !== e.b1 || (e.b1 && rs1_tag !== e.t1) ||
                    rs2_value !== e.v2 || rs2_busy !== e.b2 || (e.b2 && rs2_tag !== e.t2)) begin
                    bad++;
                    $display("FAIL %s: got rs1=%h/%0b/%0d rs2=%h/%0b/%0d required rs1=%h/%0b/%0d rs2=%h/%0b/%0d",
                             e.nm, rs1_value, rs1_busy, rs1_tag, rs2_value, rs2_busy, rs2_tag,
                             e.v1, e.b1, e.t1, e.v2, e.b2, e.t2);
                end
            end
        end
    end

    initial begin
        stim_t s;
        model_reset();
        async_reset(5'd5, 5'd0, "reset_read");

        s = idle(5'd3, 5'd0); s.iss = 1'b1; s.rd = 5'd3; s.itag = 4'd2; step(s, "issue_x3");
        s = idle(5'd3, 5'd3); step(s, "x3_busy");
        s = idle(5'd3, 5'd2); s.done = 1'b1; s.id = 5'd3; s.ctag = 4'd2; s.val = 32'hDEADBEEF;
        step(s, "x3_forward");
        s = idle(5'd3, 5'd0); step(s, "x3_stored");

        s = idle(5'd4, 5'd0); s.iss = 1'b1; s.rd = 5'd4; s.itag = 4'd1; step(s, "issue_x4_t1");
        s = idle(5'd4, 5'd0); s.iss = 1'b1; s.rd = 5'd4; s.itag = 4'd5; step(s, "issue_x4_t5");
        s = idle(5'd4, 5'd3); s.done = 1'b1; s.id = 5'd4; s.ctag = 4'd1; s.val = 32'd7;
        step(s, "x4_stale_commit");
        s = idle(5'd4, 5'd0); step(s, "x4_still_busy");
        s = idle(5'd4, 5'd0); s.done = 1'b1; s.id = 5'd4; s.ctag = 4'd5; s.val = 32'd9;
        step(s, "x4_final_commit");
        s = idle(5'd4, 5'd0); step(s, "x4_done");

        s = idle(5'd6, 5'd0); s.iss = 1'b1; s.rd = 5'd6; s.itag = 4'd0; step(s, "issue_x6_t0");
        s = idle(5'd6, 5'd0); s.iss = 1'b1; s.rd = 5'd6; s.itag = 4'd3;
        s.done = 1'b1; s.id = 5'd6; s.ctag = 4'd0; s.val = 32'h11; step(s, "x6_issue_commit");
        s = idle(5'd6, 5'd0); step(s, "x6_after");

        s = idle(5'd10, 5'd11); s.iss = 1'b1; s.rd = 5'd10; s.itag = 4'd6; step(s, "issue_x10");
        s = idle(5'd10, 5'd11); s.iss = 1'b1; s.rd = 5'd11; s.itag = 4'd7; step(s, "issue_x11");
        s = idle(5'd10, 5'd11); s.clr = 1'b1; s.iss = 1'b1; s.rd = 5'd8; s.itag = 4'd8;
        s.done = 1'b1; s.id = 5'd9; s.ctag = 4'd4; s.val = 32'h22; step(s, "flush_cycle");
        s = idle(5'd10, 5'd11); step(s, "after_flush");
        s = idle(5'd8, 5'd9); step(s, "flush_x8_x9");

        s = idle(5'd0, 5'd0); s.done = 1'b1; s.id = 5'd0; s.val = 32'hFF;
        s.iss = 1'b1; s.rd = 5'd0; s.itag = 4'd4; step(s, "x0_writes");
        s = idle(5'd0, 5'd0); step(s, "x0_read");

        s = idle(5'd12, 5'd0); s.iss = 1'b1; s.rd = 5'd12; s.itag = 4'd9; step(s, "issue_x12");
        s = idle(5'd12, 5'd13); s.rdy = 1'b0; s.done = 1'b1; s.id = 5'd12; s.ctag = 4'd9;
        s.val = 32'h77; s.clr = 1'b1; s.iss = 1'b1; s.rd = 5'd13; s.itag = 4'd2;
        step(s, "rdy_low_forward");
        s = idle(5'd12, 5'd13); step(s, "rdy_low_hold");

        async_reset(5'd3, 5'd4, "midrun_reset");

        for (int n = 0; n < 1500; n++) begin
            logic [4:0] cid;
            s = idle(5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31)),
                     5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31)));
            s.rdy  = ($urandom_range(0, 9) != 0);
            s.clr  = ($urandom_range(0, 19) == 0);
            s.iss  = $urandom_range(0, 1);
            s.rd   = 5'($urandom_range(0, 7));
            s.itag = RW'($urandom);
            s.done = ($urandom_range(0, 9) < 4);
            cid    = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) cid = s.s1;
            s.id   = cid;
            s.val  = $urandom;
            s.ctag = (m_pend[cid] >= 0 && $urandom_range(0, 3) != 0) ? RW'(m_pend[cid]) : RW'($urandom);
            step(s, "random");
        end

        s = idle(5'd0, 5'd0); step(s, "drain");
        repeat (3) @(negedge clk_in);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end
        stim_done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Architectural register file with register-status (rename) table for the RV32I out-of-order core.
- Sits between instruction fetch/issue and the reorder buffer.
- Issue reads rs1/rs2 value or pending ROB tag combinationally and marks rd as pending on a new ROB tag.
- Consumes the ROB commit port (reg_done/reg_value/reg_id/reg_tag) and the ROB clear_signal flush.

Parameters:
- ROB_WIDTH, 4, width of ROB tags; must match the reorder buffer.
- REG_COUNT, 32, number of architectural registers; fixed at 32 for RV32I, so ids are 5 bits.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-low reset
- rdy_in  input  1  ready; when low, no state changes
- clear_signal  input  1  misprediction flush from ROB
- issue_signal  input  1  1 = instruction issued this cycle with a destination
- issue_rd_id  input  5  destination register of the issued instruction
- issue_tag  input  ROB_WIDTH  ROB line assigned to the issued instruction (ROB rob_tag)
- rs1_id  input  5  source register 1 to read
- rs2_id  input  5  source register 2 to read
- rs1_value  output  32  committed value of rs1 (forwarded, see Behaviour)
- rs2_value  output  32  committed value of rs2
- rs1_busy  output  1  1 = rs1 awaits ROB result; rs1_tag valid
- rs2_busy  output  1  1 = rs2 awaits ROB result; rs2_tag valid
- rs1_tag  output  ROB_WIDTH  ROB tag producing rs1
- rs2_tag  output  ROB_WIDTH  ROB tag producing rs2
- reg_done  input  1  ROB commit strobe
- reg_value  input  32  committed value
- reg_id  input  5  committed destination register
- reg_tag  input  ROB_WIDTH  ROB line being committed

Behaviour:
- State per register i: value[i] (32 bits), tag[i] (ROB_WIDTH bits), busy[i] (1 bit).
- Reset (rst_in low, asynchronous): all value, tag and busy cleared to 0. Hence all read outputs are 0 during reset. Operation resumes on the first rising edge after rst_in goes high.
- Register x0:
  - Reads always return value 0, busy 0, tag 0.
  - Commits to x0 are discarded.
  - Issue with issue_rd_id=0 is ignored.
- Read path (purely combinational, from current state, zero latency), for each source s:
  - If s=0: value 0, busy 0, tag 0.
  - Else if reg_done & reg_id==s & busy[s] & tag[s]==reg_tag: forward. value=reg_value, busy=0.
  - Else: value[s], busy[s], tag[s].
  - Forwarding is evaluated regardless of rdy_in.
  - The read path does not see a same-cycle issue. The issue stage resolves the dependency of an instruction on itself by its own ordering; reads return pre-issue state.
- Sequential update (rising clk_in, only when rdy_in=1; with rdy_in=0 all state holds):
  - Commit: if reg_done & reg_id!=0, value[reg_id] <= reg_value. This always happens, even with a tag mismatch, because it is the architectural value.
  - Busy release: busy[reg_id] <= 0 only if busy[reg_id] & tag[reg_id]==reg_tag, and no same-cycle issue targets reg_id.
  - Issue: if issue_signal & ~clear_signal & issue_rd_id!=0, then busy[issue_rd_id] <= 1 and tag[issue_rd_id] <= issue_tag.
  - Issue and commit on the same register in the same cycle: the value write occurs, the new tag wins, and busy stays 1.
  - Flush: if clear_signal, all busy <= 0 and tags are unchanged (don't-care). Issue in this cycle is ignored. A same-cycle commit value write is still applied.
  - Priority per register: flush > issue > busy release. Value writes are independent of all three.
- Tag wrap-around: tags are reused by the ROB modulo 2^ROB_WIDTH. A stale commit whose tag equals a newer in-flight tag cannot occur, because the ROB holds at most 2^ROB_WIDTH lines and commits in order. No extra guard is required.

Test Plan:
- Reset, then read x5 -> rs1_value=0, rs1_busy=0. Assert rst_in low mid-run after writes -> all outputs 0 immediately, without waiting for a clock edge.
- Issue rd=3, tag=2; next cycle read x3 -> rs1_busy=1, rs1_tag=2. Commit id=3, tag=2, value=0xDEADBEEF -> same-cycle read gives value 0xDEADBEEF, busy=0. Next cycle the stored value is 0xDEADBEEF and busy=0.
- Issue rd=4 tag=1, then rd=4 tag=5. Commit id=4 tag=1 value=7 -> value[4]=7, busy stays 1, tag=5. Commit tag=5 value=9 -> busy=0, value=9.
- Same cycle: issue rd=6 tag=3 and commit id=6 with old matching tag 0, value=0x11 -> afterwards value=0x11, busy=1, tag=3.
- Several registers busy; pulse clear_signal together with issue rd=8 -> all busy=0, x8 not busy. A commit of value 0x22 to x9 in the same cycle is retained.
- Commit id=0 value=0xFF and issue rd=0 -> x0 reads 0, not busy. With rdy_in=0, issue/commit/clear pulses -> no state change.
